rvl_mbx_responder: RTL

//  User-clock-side command responder for the Reveal control mailbox RAM. Polls a command

---
 rtl/rvl_mbx_pkg.sv | 56 +++++
 rtl/rvl_mbx_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rvl_mbx_pkg.sv
// Shared definitions for the Reveal mailbox command responder: word offsets,
// opcodes, status codes, field positions and the responder state encoding.
package rvl_mbx_pkg;

    localparam int unsigned OFF_CMD   = 0;
    localparam int unsigned OFF_ARG0  = 1;
    localparam int unsigned OFF_ARG1  = 2;
    localparam int unsigned OFF_RESP  = 3;
    localparam int unsigned OFF_RDATA = 4;

    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_READ  = 4'd2;
    localparam logic [3:0] OP_PING  = 4'd3;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD_OP  = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam int unsigned CMD_GO_BIT      = 31;
    localparam int unsigned CMD_OP_LSB      = 0;
    localparam int unsigned SEQ_LSB         = 8;
    localparam int unsigned RESP_DONE_BIT   = 31;
    localparam int unsigned RESP_STATUS_LSB = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CMD,
        S_CHK_CMD,
        S_RD_ARG0,
        S_RD_ARG1,
        S_DECODE,
        S_EXEC,
        S_WR_RDATA,
        S_WR_RESP,
        S_CLR_CMD
    } state_t;

    function automatic logic [31:0] make_resp(input logic [1:0] st, input logic [7:0] seq);
        logic [31:0] w;
        w = '0;
        w[RESP_DONE_BIT]            = 1'b1;
        w[RESP_STATUS_LSB +: 2]     = st;
        w[SEQ_LSB +: 8]             = seq;
        return w;
    endfunction

    function automatic logic [31:0] make_cmd(input logic go, input logic [7:0] seq, input logic [3:0] op);
        logic [31:0] w;
        w = '0;
        w[CMD_GO_BIT]       = go;
        w[SEQ_LSB +: 8]     = seq;
        w[CMD_OP_LSB +: 4]  = op;
        return w;
    endfunction

endpackage

// File: rtl/rvl_mbx_responder.sv
// User-clock command responder: polls the mailbox CMD word, runs write/read/ping
// against the user register bus, then posts RDATA, RESP and clears the go bit.
module rvl_mbx_responder
    import rvl_mbx_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int unsigned POLL_INTERVAL   = 64,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned UREG_ADDR_WIDTH = 16
) (
    input  logic                       usr_clk,
    input  logic                       usr_rst_n,
    input  logic                       enable,
    output logic                       mbx_ce,
    output logic                       mbx_we,
    output logic [ADDR_WIDTH-1:0]      mbx_addr,
    output logic [DATA_WIDTH-1:0]      mbx_wdata,
    input  logic [DATA_WIDTH-1:0]      mbx_rdata,
    output logic                       ureg_req,
    output logic                       ureg_we,
    output logic [UREG_ADDR_WIDTH-1:0] ureg_addr,
    output logic [31:0]                ureg_wdata,
    input  logic                       ureg_ack,
    input  logic [31:0]                ureg_rdata,
    output logic                       busy,
    output logic                       cmd_err
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("rvl_mbx_responder: DATA_WIDTH must be 32");
    end

    localparam int unsigned PW      = (POLL_INTERVAL > 0) ? $clog2(POLL_INTERVAL + 1) : 1;
    localparam int unsigned TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t                     state;
    logic [PW-1:0]              poll_cnt;
    logic [TW-1:0]              exec_cnt;
    logic [3:0]                 op;
    logic [7:0]                 seq;
    logic [UREG_ADDR_WIDTH-1:0] arg0;
    logic [1:0]                 status;
    logic [7:0]                 last_seq;
    logic                       seq_seen;

    function automatic logic [ADDR_WIDTH-1:0] mbx_word(input int unsigned off);
        return ADDR_WIDTH'(BASE_ADDR + off);
    endfunction

    assign busy = (state != S_IDLE);

    // Every mailbox access lasts exactly one cycle: ce/we default low and are
    // raised only on the transition into the state that owns the access.
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state      <= S_IDLE;
            poll_cnt   <= '0;
            exec_cnt   <= '0;
            op         <= '0;
            seq        <= '0;
            arg0       <= '0;
            status     <= ST_OK;
            last_seq   <= '0;
            seq_seen   <= 1'b0;
            mbx_ce     <= 1'b0;
            mbx_we     <= 1'b0;
            mbx_addr   <= '0;
            mbx_wdata  <= '0;
            ureg_req   <= 1'b0;
            ureg_we    <= 1'b0;
            ureg_addr  <= '0;
            ureg_wdata <= '0;
            cmd_err    <= 1'b0;
        end else begin
            mbx_ce  <= 1'b0;
            mbx_we  <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!enable) begin
                        poll_cnt <= '0;
                    end else if (poll_cnt >= PW'(POLL_INTERVAL)) begin
                        poll_cnt <= '0;
                        mbx_ce   <= 1'b1;
                        mbx_addr <= mbx_word(OFF_CMD);
                        state    <= S_RD_CMD;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                S_RD_CMD: state <= S_CHK_CMD;
                S_CHK_CMD: begin
                    // Skipping an already-handled seq tolerates a stale go=1 word.
                    if (!mbx_rdata[CMD_GO_BIT] ||
                        (seq_seen && mbx_rdata[SEQ_LSB +: 8] == last_seq)) begin
                        state <= S_IDLE;
                    end else begin
                        op       <= mbx_rdata[CMD_OP_LSB +: 4];
                        seq      <= mbx_rdata[SEQ_LSB +: 8];
                        mbx_ce   <= 1'b1;
                        mbx_addr <= mbx_word(OFF_ARG0);
                        state    <= S_RD_ARG0;
                    end
                end
                S_RD_ARG0: begin
                    mbx_ce   <= 1'b1;
                    mbx_addr <= mbx_word(OFF_ARG1);
                    state    <= S_RD_ARG1;
                end
                S_RD_ARG1: begin
                    arg0  <= mbx_rdata[UREG_ADDR_WIDTH-1:0];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    exec_cnt <= '0;
                    status   <= ST_OK;
                    if (op == OP_WRITE || op == OP_READ) begin
                        ureg_req   <= 1'b1;
                        ureg_we    <= (op == OP_WRITE);
                        ureg_addr  <= arg0;
                        ureg_wdata <= mbx_rdata[31:0];
                        state      <= S_EXEC;
                    end else if (op == OP_PING) begin
                        mbx_ce    <= 1'b1;
                        mbx_we    <= 1'b1;
                        mbx_addr  <= mbx_word(OFF_RDATA);
                        mbx_wdata <= ~mbx_rdata;
                        state     <= S_WR_RDATA;
                    end else begin
                        status    <= ST_BAD_OP;
                        mbx_ce    <= 1'b1;
                        mbx_we    <= 1'b1;
                        mbx_addr  <= mbx_word(OFF_RESP);
                        mbx_wdata <= DATA_WIDTH'(make_resp(ST_BAD_OP, seq));
                        state     <= S_WR_RESP;
                    end
                end
                S_EXEC: begin
                    // Ack is tested first so a same-cycle ack beats the timeout.
                    if (ureg_ack) begin
                        ureg_req <= 1'b0;
                        mbx_ce   <= 1'b1;
                        mbx_we   <= 1'b1;
                        if (ureg_we) begin
                            mbx_addr  <= mbx_word(OFF_RESP);
                            mbx_wdata <= DATA_WIDTH'(make_resp(ST_OK, seq));
                            state     <= S_WR_RESP;
                        end else begin
                            mbx_addr  <= mbx_word(OFF_RDATA);
                            mbx_wdata <= DATA_WIDTH'(ureg_rdata);
                            state     <= S_WR_RDATA;
                        end
                    end else if (exec_cnt >= TW'(TO_LAST)) begin
                        ureg_req  <= 1'b0;
                        status    <= ST_TIMEOUT;
                        mbx_ce    <= 1'b1;
                        mbx_we    <= 1'b1;
                        mbx_addr  <= mbx_word(OFF_RESP);
                        mbx_wdata <= DATA_WIDTH'(make_resp(ST_TIMEOUT, seq));
                        state     <= S_WR_RESP;
                    end else begin
                        exec_cnt <= exec_cnt + 1'b1;
                    end
                end
                S_WR_RDATA: begin
                    mbx_ce    <= 1'b1;
                    mbx_we    <= 1'b1;
                    mbx_addr  <= mbx_word(OFF_RESP);
                    mbx_wdata <= DATA_WIDTH'(make_resp(status, seq));
                    state     <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    mbx_ce    <= 1'b1;
                    mbx_we    <= 1'b1;
                    mbx_addr  <= mbx_word(OFF_CMD);
                    mbx_wdata <= DATA_WIDTH'(make_cmd(1'b0, seq, op));
                    state     <= S_CLR_CMD;
                end
                S_CLR_CMD: begin
                    last_seq <= seq;
                    seq_seen <= 1'b1;
                    cmd_err  <= (status != ST_OK);
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
